eth_rx_header_strip: RTL and testbench
======================================

Name: eth_rx_header_strip

Overview:
- Receive-side stage that consumes the 64-bit AXI-Stream Ethernet frames produced by the MPI/Ethernet stimulus/TX path.
- Parses and strips the 14-byte Ethernet header and filters on destination MAC.
- Realigns the payload to lane 0 and emits it on an output stream.
- Emits header fields on a separate metadata handshake. Feeds the downstream MPI header decoder.

Parameters:
- LOCAL_MAC, 48'hfa163e55ca02, MAC accepted by the filter.
- FILTER_EN, 1, 1 = drop frames whose dst MAC is neither LOCAL_MAC nor broadcast (all ones); 0 = accept all frames.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- stream_in_DATA  in  64  frame data; byte n of a beat is on bits [8n+7:8n], first byte on the wire is in lane 0.
- stream_in_KEEP  in  8  byte enables; contiguous from lane 0. Only the last beat may be partial.
- stream_in_LAST  in  1  last beat of frame.
- stream_in_VALID  in  1.
- stream_in_READY  out  1.
- stream_out_DATA  out  64  realigned payload.
- stream_out_KEEP  out  8.
- stream_out_LAST  out  1.
- stream_out_VALID  out  1.
- stream_out_READY  in  1.
- meta_mac_dst  out  48  dst MAC, header bytes 0-5; byte 0 in bits [47:40].
- meta_mac_src  out  48  src MAC, header bytes 6-11; same byte order.
- meta_ethertype  out  16  header bytes 12-13, byte 12 in bits [15:8].
- meta_valid  out  1.
- meta_ready  in  1.
- drop_pulse  out  1  one-cycle pulse when a frame is filtered.
- runt_pulse  out  1  one-cycle pulse when a frame of 14 bytes or fewer ends.
- rx_frame_count  out  32  frames forwarded; wraps.
- drop_count  out  32  filtered frames plus runts; wraps.

Behaviour:
- Reset values: all outputs 0, except stream_in_READY = 0. State = HDR0. Counters 0. The pipeline and meta registers are cleared, so a partial frame in flight is discarded with no pulse.
- An input beat transfers on VALID&READY; an output beat transfers likewise.
- State HDR0:
  - stream_in_READY = !meta_valid.
  - On a beat, capture mac_dst and mac_src[47:32].
  - If the beat is LAST: runt_pulse, drop_count++, stay in HDR0.
  - Else if FILTER_EN and dst MAC is neither LOCAL_MAC nor broadcast: drop_pulse, drop_count++, go to DROP.
  - Else go to HDR1.
- State HDR1:
  - READY = 1. Capture mac_src[31:0] (lanes 0-3) and ethertype (lanes 4-5). Save lanes 7:6 and KEEP[7:6] into the carry register.
  - If LAST and KEEP[6] = 0 (14 bytes or fewer): runt_pulse, drop_count++, go to HDR0, no meta emitted.
  - If LAST and KEEP[6] = 1: meta_valid <= 1, go to FLUSH.
  - Else: meta_valid <= 1, go to PAYLOAD.
- State PAYLOAD:
  - READY = (!stream_out_VALID || stream_out_READY).
  - Each input beat produces one output beat: DATA = {in[47:0], carry[15:0]}, KEEP = {in_keep[5:0], carry_keep[1:0]}. Then carry <= in lanes 7:6.
  - On the LAST input beat with KEEP[6] = 0: the output beat is LAST, rx_frame_count++, go to HDR0.
  - On the LAST input beat with KEEP[6] = 1: the output beat is not LAST, go to FLUSH.
- State FLUSH:
  - READY = 0. When the output register can load, emit DATA = {48'h0, carry}, KEEP = {6'b0, carry_keep}, LAST = 1. Then rx_frame_count++ and go to HDR0.
- State DROP: READY = 1, discard beats, go to HDR0 on LAST.
- Output register:
  - Single stage. stream_out_* hold while VALID && !READY.
  - Zero-bubble throughput: 1 beat/cycle in PAYLOAD with READY held high.
  - Latency from input beat to output beat is 1 cycle.
- Meta register:
  - Fields stable while meta_valid = 1. Cleared on meta_valid&meta_ready.
  - Payload flows independently of meta acceptance. The next frame's first beat stalls in HDR0 until meta is accepted.
- Simultaneous meta acceptance and a new frame start: READY is computed from the registered meta_valid, so the new frame is accepted one cycle later.
- Counters increment at most once per cycle.

Test Plan:
- 64-byte frame, dst = LOCAL_MAC, src = 0cc47a88c047, ethertype 0x0800, payload bytes 0x00..0x31 (50 bytes), both READYs held at 1:
  - meta fields match exactly.
  - 7 output beats; the first beat data is bytes 0x07..0x00.
  - The last beat has KEEP = 8'h03 and LAST = 1.
  - rx_frame_count = 1.
- Frame with dst = 112233445566 and FILTER_EN = 1: no output beats, no meta, drop_pulse once, drop_count = 1. The same frame to ffffffffffff is forwarded.
- 14-byte frame (2 beats, second KEEP = 8'h3F): runt_pulse, no meta, no output. A 15-byte frame gives meta plus one beat with KEEP = 8'h01 and LAST = 1.
- Payload length a multiple of 8 (16 bytes → input last KEEP = 8'h3F): 2 output beats, last KEEP = 8'hFF, no FLUSH beat.
- Random stream_out_READY (50% duty) and meta_ready held 0 for 20 cycles across back-to-back frames:
  - payload bytes identical to the sent payload, with no loss or duplication.
  - the second frame stalls in HDR0 until meta is accepted.
- Assert aresetn low mid-payload: all outputs return to 0 immediately. The next full frame is parsed correctly and counters restart from 0.

Source files
------------

// File: rtl/eth_rx_header_strip.sv
// Ethernet RX stage: parses and strips the 14-byte header, filters on destination MAC,
// realigns the payload to lane 0 and presents the header fields on a metadata handshake.
module eth_rx_header_strip #(
  parameter logic [47:0] LOCAL_MAC = 48'hfa163e55ca02,
  parameter bit          FILTER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic [63:0] stream_in_DATA,
  input  logic [7:0]  stream_in_KEEP,
  input  logic        stream_in_LAST,
  input  logic        stream_in_VALID,
  output logic        stream_in_READY,
  output logic [63:0] stream_out_DATA,
  output logic [7:0]  stream_out_KEEP,
  output logic        stream_out_LAST,
  output logic        stream_out_VALID,
  input  logic        stream_out_READY,
  output logic [47:0] meta_mac_dst,
  output logic [47:0] meta_mac_src,
  output logic [15:0] meta_ethertype,
  output logic        meta_valid,
  input  logic        meta_ready,
  output logic        drop_pulse,
  output logic        runt_pulse,
  output logic [31:0] rx_frame_count,
  output logic [31:0] drop_count
);

  typedef enum logic [2:0] {
    HDR0    = 3'd0,
    HDR1    = 3'd1,
    PAYLOAD = 3'd2,
    FLUSH   = 3'd3,
    DROP    = 3'd4
  } state_t;

  state_t      state_r, state_next_s;
  logic        in_ready_s;
  logic        out_can_load_s;
  logic        cap_hdr0_s, cap_carry_s, ld_meta_s, ld_out_s;
  logic        runt_s, drop_s, rx_inc_s;
  logic [63:0] out_data_s;
  logic [7:0]  out_keep_s;
  logic        out_last_s;
  logic [47:0] beat_dst_s;
  logic [31:0] beat_src_lo_s;
  logic [15:0] beat_type_s;

  logic [47:0] hdr_dst_r;
  logic [15:0] hdr_src_hi_r;
  logic [15:0] carry_r;
  logic [1:0]  carry_keep_r;
  logic [63:0] out_data_r;
  logic [7:0]  out_keep_r;
  logic        out_last_r, out_valid_r;
  logic [47:0] meta_dst_r, meta_src_r;
  logic [15:0] meta_type_r;
  logic        meta_valid_r;
  logic        drop_pulse_r, runt_pulse_r;
  logic [31:0] rx_count_r, drop_count_r;

  // Header fields are big-endian on the wire: the first received byte is the MSB.
  assign beat_dst_s    = {stream_in_DATA[7:0],   stream_in_DATA[15:8],  stream_in_DATA[23:16],
                          stream_in_DATA[31:24], stream_in_DATA[39:32], stream_in_DATA[47:40]};
  assign beat_src_lo_s = {stream_in_DATA[7:0],   stream_in_DATA[15:8],
                          stream_in_DATA[23:16], stream_in_DATA[31:24]};
  assign beat_type_s   = {stream_in_DATA[39:32], stream_in_DATA[47:40]};
  assign out_can_load_s = !out_valid_r || stream_out_READY;

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_r <= HDR0;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next_s = state_r;
    in_ready_s   = 1'b0;
    cap_hdr0_s   = 1'b0;
    cap_carry_s  = 1'b0;
    ld_meta_s    = 1'b0;
    ld_out_s     = 1'b0;
    out_data_s   = 64'h0;
    out_keep_s   = 8'h0;
    out_last_s   = 1'b0;
    runt_s       = 1'b0;
    drop_s       = 1'b0;
    rx_inc_s     = 1'b0;
    case (state_r)
      HDR0: begin
        // A new frame waits here until the previous frame's metadata is taken.
        in_ready_s = !meta_valid_r;
        if (stream_in_VALID && in_ready_s) begin
          cap_hdr0_s = 1'b1;
          if (stream_in_LAST) begin
            runt_s = 1'b1;
          end else if (FILTER_EN && (beat_dst_s != LOCAL_MAC) && (beat_dst_s != 48'hffffffffffff)) begin
            drop_s       = 1'b1;
            state_next_s = DROP;
          end else begin
            state_next_s = HDR1;
          end
        end else begin
          state_next_s = HDR0;
        end
      end
      HDR1: begin
        in_ready_s = 1'b1;
        if (stream_in_VALID) begin
          cap_carry_s = 1'b1;
          if (stream_in_LAST && !stream_in_KEEP[6]) begin
            runt_s       = 1'b1;
            state_next_s = HDR0;
          end else begin
            ld_meta_s    = 1'b1;
            state_next_s = stream_in_LAST ? FLUSH : PAYLOAD;
          end
        end else begin
          state_next_s = HDR1;
        end
      end
      PAYLOAD: begin
        in_ready_s = out_can_load_s;
        if (stream_in_VALID && in_ready_s) begin
          ld_out_s    = 1'b1;
          cap_carry_s = 1'b1;
          out_data_s  = {stream_in_DATA[47:0], carry_r};
          out_keep_s  = {stream_in_KEEP[5:0], carry_keep_r};
          out_last_s  = stream_in_LAST && !stream_in_KEEP[6];
          if (stream_in_LAST) begin
            if (stream_in_KEEP[6]) begin
              state_next_s = FLUSH;
            end else begin
              rx_inc_s     = 1'b1;
              state_next_s = HDR0;
            end
          end else begin
            state_next_s = PAYLOAD;
          end
        end else begin
          state_next_s = PAYLOAD;
        end
      end
      FLUSH: begin
        if (out_can_load_s) begin
          ld_out_s     = 1'b1;
          out_data_s   = {48'h0, carry_r};
          out_keep_s   = {6'b0, carry_keep_r};
          out_last_s   = 1'b1;
          rx_inc_s     = 1'b1;
          state_next_s = HDR0;
        end else begin
          state_next_s = FLUSH;
        end
      end
      DROP: begin
        in_ready_s = 1'b1;
        if (stream_in_VALID && stream_in_LAST) begin
          state_next_s = HDR0;
        end else begin
          state_next_s = DROP;
        end
      end
      default: begin
        state_next_s = HDR0;
      end
    endcase
  end

  // Header bytes from the first beat and the two-lane carry for realignment.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      hdr_dst_r    <= 48'h0;
      hdr_src_hi_r <= 16'h0;
      carry_r      <= 16'h0;
      carry_keep_r <= 2'b0;
    end else begin
      if (cap_hdr0_s) begin
        hdr_dst_r    <= beat_dst_s;
        hdr_src_hi_r <= {stream_in_DATA[55:48], stream_in_DATA[63:56]};
      end
      if (cap_carry_s) begin
        carry_r      <= stream_in_DATA[63:48];
        carry_keep_r <= stream_in_KEEP[7:6];
      end
    end
  end

  // Metadata register: loads when the second header beat arrives, clears on acceptance.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      meta_valid_r <= 1'b0;
      meta_dst_r   <= 48'h0;
      meta_src_r   <= 48'h0;
      meta_type_r  <= 16'h0;
    end else if (ld_meta_s) begin
      meta_valid_r <= 1'b1;
      meta_dst_r   <= hdr_dst_r;
      meta_src_r   <= {hdr_src_hi_r, beat_src_lo_s};
      meta_type_r  <= beat_type_s;
    end else if (meta_valid_r && meta_ready) begin
      meta_valid_r <= 1'b0;
      meta_dst_r   <= 48'h0;
      meta_src_r   <= 48'h0;
      meta_type_r  <= 16'h0;
    end
  end

  // Single-stage output register; contents hold while stalled.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= 64'h0;
      out_keep_r  <= 8'h0;
      out_last_r  <= 1'b0;
    end else if (ld_out_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= out_data_s;
      out_keep_r  <= out_keep_s;
      out_last_r  <= out_last_s;
    end else if (out_valid_r && stream_out_READY) begin
      out_valid_r <= 1'b0;
    end
  end

  // Event pulses and wrapping statistics counters.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      drop_pulse_r <= 1'b0;
      runt_pulse_r <= 1'b0;
      rx_count_r   <= 32'd0;
      drop_count_r <= 32'd0;
    end else begin
      drop_pulse_r <= drop_s;
      runt_pulse_r <= runt_s;
      if (rx_inc_s) begin
        rx_count_r <= rx_count_r + 32'd1;
      end
      if (drop_s || runt_s) begin
        drop_count_r <= drop_count_r + 32'd1;
      end
    end
  end

  assign stream_in_READY  = aresetn && in_ready_s;
  assign stream_out_DATA  = out_data_r;
  assign stream_out_KEEP  = out_keep_r;
  assign stream_out_LAST  = out_last_r;
  assign stream_out_VALID = out_valid_r;
  assign meta_mac_dst     = meta_dst_r;
  assign meta_mac_src     = meta_src_r;
  assign meta_ethertype   = meta_type_r;
  assign meta_valid       = meta_valid_r;
  assign drop_pulse       = drop_pulse_r;
  assign runt_pulse       = runt_pulse_r;
  assign rx_frame_count   = rx_count_r;
  assign drop_count       = drop_count_r;

endmodule

// File: tb/tb_eth_rx_header_strip.sv
// Scoreboard bench for eth_rx_header_strip: stimulus pushes expected beats/metadata,
// a negedge monitor pops and compares whatever the DUT hands over.
module tb_eth_rx_header_strip;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  localparam logic [47:0] MAC_LOCAL = 48'hfa163e55ca02;
  localparam logic [47:0] MAC_SRC   = 48'h0cc47a88c047;
  localparam logic [47:0] MAC_BCAST = 48'hffffffffffff;
  localparam logic [47:0] MAC_OTHER = 48'h112233445566;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_last, in_valid;
  logic        stream_in_READY;
  logic [63:0] stream_out_DATA;
  logic [7:0]  stream_out_KEEP;
  logic        stream_out_LAST, stream_out_VALID, stream_out_READY;
  logic [47:0] meta_mac_dst, meta_mac_src;
  logic [15:0] meta_ethertype;
  logic        meta_valid, meta_ready;
  logic        drop_pulse, runt_pulse;
  logic [31:0] rx_frame_count, drop_count;

  logic out_rdy_fixed, rand_rdy_en, rand_bit;

  int total = 0;
  int bad = 0;
  int drop_seen = 0;
  int runt_seen = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  logic [111:0] meta_q[$];
  byte_q_t fb, fa;
  logic [47:0] cur_dst, cur_src;
  logic [15:0] cur_type;
  bit a_done;

  always #5 clk = ~clk;

  assign stream_out_READY = rand_rdy_en ? rand_bit : out_rdy_fixed;

  eth_rx_header_strip #(.LOCAL_MAC(MAC_LOCAL), .FILTER_EN(1'b1)) dut (
    .clk(clk), .aresetn(aresetn),
    .stream_in_DATA(in_data), .stream_in_KEEP(in_keep), .stream_in_LAST(in_last),
    .stream_in_VALID(in_valid), .stream_in_READY(stream_in_READY),
    .stream_out_DATA(stream_out_DATA), .stream_out_KEEP(stream_out_KEEP),
    .stream_out_LAST(stream_out_LAST), .stream_out_VALID(stream_out_VALID),
    .stream_out_READY(stream_out_READY),
    .meta_mac_dst(meta_mac_dst), .meta_mac_src(meta_mac_src), .meta_ethertype(meta_ethertype),
    .meta_valid(meta_valid), .meta_ready(meta_ready),
    .drop_pulse(drop_pulse), .runt_pulse(runt_pulse),
    .rx_frame_count(rx_frame_count), .drop_count(drop_count)
  );

  task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Random output backpressure, refreshed just after each active edge.
  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard on every output/meta transfer, counts pulses.
  always @(negedge clk) begin
    beat_t o, e;
    logic [63:0] m;
    logic [111:0] em;
    if (aresetn) begin
      if (stream_out_VALID && stream_out_READY) begin
        o.d = stream_out_DATA; o.k = stream_out_KEEP; o.l = stream_out_LAST;
        obs_q.push_back(o);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL out_unexpected: actual=%0h required=none", o.d);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 8; i++) m[8*i +: 8] = e.k[i] ? 8'hff : 8'h00;
          check("out_data", o.d & m, e.d & m);
          check("out_keep", o.k, e.k);
          check("out_last", o.l, e.l);
        end
      end
      if (meta_valid && meta_ready) begin
        if (meta_q.size() == 0) begin
          total++; bad++;
          $display("FAIL meta_unexpected: actual=%0h required=none", meta_mac_dst);
        end else begin
          em = meta_q.pop_front();
          check("meta_fields", {meta_mac_dst, meta_mac_src, meta_ethertype}, em);
        end
      end
      if (drop_pulse) drop_seen++;
      if (runt_pulse) runt_seen++;
    end
  end

  task automatic build_frame(input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] et, input int plen, input logic [7:0] p0);
    fb.delete();
    for (int i = 5; i >= 0; i--) fb.push_back(dst[8*i +: 8]);
    for (int i = 5; i >= 0; i--) fb.push_back(src[8*i +: 8]);
    fb.push_back(et[15:8]);
    fb.push_back(et[7:0]);
    for (int i = 0; i < plen; i++) fb.push_back(8'(p0 + i));
    cur_dst = dst; cur_src = src; cur_type = et;
  endtask

  // Expected response of a forwarded frame: its metadata and payload in 8-byte beats.
  task automatic push_exp();
    int p, nb;
    beat_t e;
    meta_q.push_back({cur_dst, cur_src, cur_type});
    p  = fb.size() - 14;
    nb = (p + 7) / 8;
    for (int b = 0; b < nb; b++) begin
      e.d = 64'h0; e.k = 8'h0;
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i < p) begin
          e.d[8*i +: 8] = fb[14 + b * 8 + i];
          e.k[i] = 1'b1;
        end
      end
      e.l = (b == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_frame(input byte_q_t f, input int nmax);
    int nb, to;
    logic [63:0] d;
    logic [7:0] k;
    nb = (f.size() + 7) / 8;
    for (int b = 0; b < nb && b < nmax; b++) begin
      d = 64'h0; k = 8'h0;
      for (int i = 0; i < 8; i++) begin
        if (b * 8 + i < f.size()) begin
          d[8*i +: 8] = f[b * 8 + i];
          k[i] = 1'b1;
        end
      end
      in_data = d; in_keep = k; in_last = (b == nb - 1); in_valid = 1'b1;
      to = 0;
      @(negedge clk);
      while (!stream_in_READY && to < 1000) begin
        @(negedge clk);
        to++;
      end
      if (to >= 1000) begin
        total++; bad++;
        $display("FAIL send_timeout: actual=stalled required=accepted");
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 64'h0; in_keep = 8'h0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || meta_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("FAIL drain_timeout: actual=%0d pending required=0", exp_q.size() + meta_q.size());
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0, r0, n;
    aresetn = 1'b0; in_data = 64'h0; in_keep = 8'h0; in_last = 1'b0; in_valid = 1'b0;
    meta_ready = 1'b1; out_rdy_fixed = 1'b1; rand_rdy_en = 1'b0; a_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {stream_in_READY, stream_out_VALID, stream_out_LAST, stream_out_KEEP,
                         meta_valid, drop_pulse, runt_pulse}, 112'h0);
    check("reset_data", {stream_out_DATA, meta_mac_dst}, 112'h0);
    check("reset_cnt", {rx_frame_count, drop_count}, 112'h0);
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // 64-byte frame to the local MAC
    obs_q.delete();
    build_frame(MAC_LOCAL, MAC_SRC, 16'h0800, 50, 8'h00);
    meta_q.push_back({MAC_LOCAL, MAC_SRC, 16'h0800});
    push_exp();
    void'(meta_q.pop_back());
    send_frame(fb, 100);
    wait_drain();
    check("t1_beats", obs_q.size(), 7);
    if (obs_q.size() == 7) begin
      check("t1_first_data", obs_q[0].d, 64'h0706050403020100);
      check("t1_last_keep", {obs_q[6].k, obs_q[6].l}, {8'h03, 1'b1});
    end
    check("t1_rx_count", rx_frame_count, 1);

    // filtered destination, then the same frame to broadcast
    obs_q.delete(); d0 = drop_seen;
    build_frame(MAC_OTHER, MAC_SRC, 16'h0800, 16, 8'h40);
    send_frame(fb, 100);
    wait_drain();
    check("t2_drop_beats", obs_q.size(), 0);
    check("t2_drop_pulse", drop_seen - d0, 1);
    check("t2_drop_count", drop_count, 1);
    check("t2_meta_idle", meta_valid, 1'b0);
    build_frame(MAC_BCAST, MAC_SRC, 16'h0800, 16, 8'h40);
    push_exp();
    send_frame(fb, 100);
    wait_drain();
    check("t2_bcast_beats", obs_q.size(), 2);
    check("t2_rx_count", rx_frame_count, 2);

    // 14-byte runt, then 15-byte minimal frame
    obs_q.delete(); r0 = runt_seen;
    build_frame(MAC_LOCAL, MAC_SRC, 16'h88b5, 0, 8'h00);
    send_frame(fb, 100);
    wait_drain();
    check("t3_runt_pulse", runt_seen - r0, 1);
    check("t3_runt_beats", obs_q.size(), 0);
    check("t3_drop_count", drop_count, 2);
    build_frame(MAC_LOCAL, MAC_SRC, 16'h88b5, 1, 8'h5a);
    push_exp();
    send_frame(fb, 100);
    wait_drain();
    check("t3_min_beats", obs_q.size(), 1);
    if (obs_q.size() == 1) check("t3_min_keep", {obs_q[0].k, obs_q[0].l}, {8'h01, 1'b1});
    check("t3_rx_count", rx_frame_count, 3);

    // payload length a multiple of 8: no flush beat
    obs_q.delete();
    build_frame(MAC_LOCAL, MAC_SRC, 16'h86dd, 16, 8'h80);
    push_exp();
    send_frame(fb, 100);
    wait_drain();
    check("t4_beats", obs_q.size(), 2);
    if (obs_q.size() == 2) check("t4_last_keep", {obs_q[1].k, obs_q[1].l}, {8'hff, 1'b1});
    check("t4_rx_count", rx_frame_count, 4);

    // back-to-back frames, random output ready, metadata withheld
    obs_q.delete();
    meta_ready = 1'b0; rand_rdy_en = 1'b1;
    build_frame(MAC_LOCAL, MAC_SRC, 16'h0800, 23, 8'h10);
    push_exp();
    fa = fb;
    build_frame(MAC_BCAST, 48'h0a0b0c0d0e0f, 16'h0806, 37, 8'hc0);
    push_exp();
    fork
      begin
        send_frame(fa, 100);
        a_done = 1'b1;
        send_frame(fb, 100);
      end
      begin
        n = 0;
        while (!a_done && n < 1000) begin
          @(posedge clk);
          n++;
        end
        repeat (2) @(negedge clk);
        check("t5_stall", {meta_valid, stream_in_READY}, {1'b1, 1'b0});
        repeat (17) @(negedge clk);
        check("t5_stall_late", {meta_valid, stream_in_READY}, {1'b1, 1'b0});
        @(posedge clk);
        #1;
        meta_ready = 1'b1;
      end
    join
    wait_drain();
    rand_rdy_en = 1'b0;
    check("t5_beats", obs_q.size(), 8);
    check("t5_rx_count", rx_frame_count, 6);

    // reset mid-payload with data and metadata held
    meta_ready = 1'b0; out_rdy_fixed = 1'b0;
    build_frame(MAC_LOCAL, MAC_SRC, 16'h0800, 40, 8'h20);
    send_frame(fb, 3);
    check("t6_pre_busy", {stream_out_VALID, meta_valid}, {1'b1, 1'b1});
    aresetn = 1'b0;
    #1;
    check("t6_rst_ctrl", {stream_in_READY, stream_out_VALID, stream_out_LAST, stream_out_KEEP,
                          meta_valid, drop_pulse, runt_pulse}, 112'h0);
    check("t6_rst_data", {stream_out_DATA, meta_mac_dst}, 112'h0);
    check("t6_rst_cnt", {rx_frame_count, drop_count}, 112'h0);
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1; meta_ready = 1'b1; out_rdy_fixed = 1'b1;
    @(posedge clk);
    #1;
    obs_q.delete();
    build_frame(MAC_LOCAL, MAC_SRC, 16'h0800, 50, 8'h00);
    push_exp();
    send_frame(fb, 100);
    wait_drain();
    check("t6_beats", obs_q.size(), 7);
    check("t6_counts", {rx_frame_count, drop_count}, {32'd1, 32'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
